// File: rtl/ts_extend_capture.sv
// Extends a 32-bit free-running count to a {epoch, count} timestamp, captures it on
// event strobes into a small FIFO, and presents the buffered entries on valid/ready.
module ts_extend_capture #(
  parameter int EPOCH_W = 16,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int DROP_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           count,
  input  logic                  overflow,
  input  logic                  event_in,
  output logic [32+EPOCH_W-1:0] ts_data,
  output logic                  ts_valid,
  input  logic                  ts_ready,
  output logic                  fifo_full,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic [EPOCH_W-1:0]    epoch
);

  localparam int TS_W = 32 + EPOCH_W;
  localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W + 1)'(DEPTH);

  logic [TS_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   occ;
  logic              ovf_q;

  logic ovf_rise;
  logic pop;
  logic push;
  logic drop;

  // Status flags come from registered occupancy only, so ts_ready never reaches them.
  assign ts_valid  = (occ != '0);
  assign fifo_full = (occ == FULL_OCC);

  assign ovf_rise = overflow && !ovf_q;
  assign pop      = ts_valid && ts_ready;
  assign push     = event_in && (!fifo_full || pop);
  assign drop     = event_in && fifo_full && !pop;

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign ts_data = ts_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, exactly like the flops it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      epoch    <= '0;
      ovf_q    <= 1'b0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      ovf_q <= overflow;
      if (ovf_rise) begin
        epoch <= epoch + 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // NOTE: the data array has no reset; validity is tracked by the pointers and
  // occupancy, which keeps the storage as plain flops/RAM without a reset tree.
  // The epoch written is the pre-increment register, so a terminal count coincident
  // with an overflow edge is stamped with the old epoch.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= {epoch, count};
    end
  end

endmodule

// File: tb/tb_ts_extend_capture.sv
// Self-checking bench for ts_extend_capture: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_ts_extend_capture;

  localparam int EPOCH_W = 16;
  localparam int DEPTH   = 4;
  localparam int DROP_W  = 8;
  localparam int TS_W    = 32 + EPOCH_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       count;
  logic              overflow;
  logic              event_in;
  logic [TS_W-1:0]   ts_data;
  logic              ts_valid;
  logic              ts_ready;
  logic              fifo_full;
  logic [DROP_W-1:0] drop_cnt;
  logic [EPOCH_W-1:0] epoch;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [TS_W-1:0] mq[$];
  int              m_epoch;
  bit              m_ovfq;
  int              m_drop;

  ts_extend_capture #(
    .EPOCH_W(EPOCH_W),
    .DEPTH  (DEPTH),
    .ADDR_W (2),
    .DROP_W (DROP_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .count    (count),
    .overflow (overflow),
    .event_in (event_in),
    .ts_data  (ts_data),
    .ts_valid (ts_valid),
    .ts_ready (ts_ready),
    .fifo_full(fifo_full),
    .drop_cnt (drop_cnt),
    .epoch    (epoch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input logic [31:0] cnt, input bit ovf,
                            input bit ev, input bit rdy);
    bit full;
    bit do_pop;
    if (rst) begin
      mq.delete();
      m_epoch = 0;
      m_ovfq  = 0;
      m_drop  = 0;
    end else begin
      full   = (mq.size() == DEPTH);
      do_pop = (mq.size() != 0) && rdy;
      if (do_pop) void'(mq.pop_front());
      if (ev && (!full || do_pop)) mq.push_back({m_epoch[EPOCH_W-1:0], cnt});
      if (ev && full && !do_pop && m_drop < 255) m_drop++;
      if (ovf && !m_ovfq) m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
      m_ovfq = ovf;
    end
  endtask

  task automatic compare_model();
    logic [TS_W-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    check("ts_valid", 64'(ts_valid), 64'(mq.size() != 0));
    check("fifo_full", 64'(fifo_full), 64'(mq.size() == DEPTH));
    check("ts_data", 64'(ts_data), 64'(head));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("epoch", 64'(epoch), 64'(m_epoch));
  endtask

  // Drives one cycle of inputs from a negedge, advances the model at the posedge,
  // and compares all outputs at the following negedge.
  task automatic cyc(input bit rst, input logic [31:0] cnt, input bit ovf,
                     input bit ev, input bit rdy);
    reset    = rst;
    count    = cnt;
    overflow = ovf;
    event_in = ev;
    ts_ready = rdy;
    @(posedge clk);
    model_step(rst, cnt, ovf, ev, rdy);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    cyc(1, 32'h0, 0, 0, 0);
    cyc(1, 32'h0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rc;
    bit          ro;
    reset = 1'b1; count = '0; overflow = 1'b0; event_in = 1'b0; ts_ready = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_valid", 64'(ts_valid), 64'd0);
    check("rst_data", 64'(ts_data), 64'd0);

    // Single capture at count 5 with consumer ready
    for (int i = 0; i <= 12; i++) begin
      cyc(0, 32'(i), 0, (i == 5), 1);
      if (i == 5) begin
        check("cap5_valid", 64'(ts_valid), 64'd1);
        check("cap5_data", 64'(ts_data), 64'h0000_0000_0005);
      end
      if (i == 6) check("cap5_popped", 64'(ts_valid), 64'd0);
    end

    // Event coincident with overflow edge keeps old epoch; next cycle sees new one
    do_reset();
    cyc(0, 32'hFFFF_FFFF, 1, 1, 0);
    check("wrap_epoch", 64'(epoch), 64'd1);
    check("wrap_first", 64'(ts_data), 64'h0000_FFFF_FFFF);
    cyc(0, 32'h0, 0, 1, 0);
    cyc(0, 32'h1, 0, 0, 1);
    check("wrap_second", 64'(ts_data), 64'h0001_0000_0000);
    cyc(0, 32'h2, 0, 0, 1);

    // Held overflow increments once; release and reassert increments again
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 32'hFFFF_FFFF, 1, 0, 0);
    check("hold_epoch", 64'(epoch), 64'd1);
    cyc(0, 32'h0, 0, 0, 0);
    cyc(0, 32'hFFFF_FFFF, 1, 0, 0);
    check("reassert_epoch", 64'(epoch), 64'd2);

    // Six events with no consumer: four stored, two dropped
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 32'(100 + i), 0, 1, 0);
    check("burst_full", 64'(fifo_full), 64'd1);
    check("burst_drops", 64'(drop_cnt), 64'd2);
    // Full with simultaneous push and pop: accepted, no drop
    cyc(0, 32'd200, 0, 1, 1);
    check("fullpp_full", 64'(fifo_full), 64'd1);
    check("fullpp_drops", 64'(drop_cnt), 64'd2);
    check("fullpp_head", 64'(ts_data), 64'd101);
    for (int i = 0; i < 5; i++) cyc(0, 32'(300 + i), 0, 0, 1);
    check("drained", 64'(ts_valid), 64'd0);

    // Reset mid-operation with epoch 5 and three entries queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 32'hFFFF_FFFF, 1, 0, 0);
      cyc(0, 32'h0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 32'(i), 0, 1, 0);
    check("pre_rst_epoch", 64'(epoch), 64'd5);
    cyc(1, 32'h0, 0, 0, 0);
    check("mid_rst_valid", 64'(ts_valid), 64'd0);
    check("mid_rst_epoch", 64'(epoch), 64'd0);
    check("mid_rst_drops", 64'(drop_cnt), 64'd0);

    // Drop counter saturation with overflow toggling alongside
    for (int i = 0; i < 4; i++) cyc(0, 32'(i), 0, 1, 0);
    for (int i = 0; i < 520; i++) cyc(0, 32'hFFFF_FFFF, (i % 2) == 0, (i % 2) == 0, 0);
    check("drop_sat", 64'(drop_cnt), 64'd255);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      ro = (rc == 32'hFFFF_FFFF) && ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 199) == 0, rc, ro, $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
